fusion_mac: RTL and testbench
=============================

Name: fusion_mac

Overview:
- Parametrised Bit Fusion unit: (OPW/2)^2 2-bit bitbrick instances fused into one multiply-accumulate engine.
- Runtime-selectable precision: 2-bit, 4-bit or 8-bit lanes, each signed or unsigned.
- Each beat computes a lane-wise dot product of A and B; beats of a burst are accumulated.
- Sits between the operand buffers and the output/ReLU stage of a PE column.

Parameters:
- OPW, 8, operand bus width in bits; power of two, >= 8; bricks = (OPW/2)^2.
- ACC_W, 32, accumulator/result width; must be >= 2*OPW+4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_first  in  1  first beat of burst; loads accumulator, samples mode/sign.
- in_last  in  1  last beat of burst; result emitted.
- mode  in  2  0=2b lanes, 1=4b lanes, 2=8b lanes, 3=treated as 8b.
- s_a  in  1  A lanes signed.
- s_b  in  1  B lanes signed.
- a  in  OPW  operand A; lane 0 in LSBs.
- b  in  OPW  operand B; lane 0 in LSBs.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  ACC_W  accumulated dot product, two's complement if s_a|s_b, else unsigned.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, accumulator=0, all stage valids=0, in_ready=1 after release. Reset mid-burst discards the burst; the next burst must start with in_first.
- Per beat, lane width L = 2/4/8: result = sum over i of a_lane[i]*b_lane[i]. Lane count is OPW/L; lanes are sign-extended from the lane MSB when the corresponding sign flag is set.
- Bricks: each brick gets s_x/s_y set only when it holds the MSB 2-bit slice of a signed lane. Per-brick shift = 2*(slice_a + slice_b) within the lane. Cross-lane bricks are gated to zero in the 2b and 4b modes.
- Pipeline:
  - S1 registers brick products.
  - S2 registers the shift-add reduced beat sum, sign-extended to ACC_W.
  - S3 accumulates.
- Latency: out_valid rises 3 cycles after the in_last beat is accepted, when no stall occurs.
- Global stall: stall = out_valid & ~out_ready. in_ready = ~stall. While stalled, all pipeline registers and out_data hold.
- out_valid falls the cycle after the out_valid & out_ready handshake, unless a new result is completing in that same cycle.
- Accumulate rules:
  - in_first beat: acc = beat_sum.
  - Other beats: acc = acc + beat_sum, wrapping modulo 2^ACC_W.
  - in_first & in_last together: single-beat burst.
- mode, s_a and s_b are sampled on the in_first beat and held for the burst; their values on later beats are ignored.
- Beats without in_first are accepted before any first beat after reset; they accumulate onto 0.
- Back-to-back bursts: a new in_first may be accepted in the cycle after the previous in_last with no bubble.

Optional Feature:
- Macro: FUSION_MAC_SAT_EN.
- Defined: accumulation saturates. Signed bursts clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; unsigned bursts clamp to 2^ACC_W-1. A sticky per-burst flag is appended as extra output out_sat (1 bit), valid with out_valid.
- Undefined: accumulation wraps and port out_sat does not exist.

Decomposition:
- Package fusion_pkg:
  - Mode constants MODE_2B=2'd0, MODE_4B=2'd1, MODE_8B=2'd2.
  - Function lane_bits(mode).
  - Brick-index/shift helper function.
- Sub-module: the existing bitbrick, instantiated (OPW/2)^2 times in a generate loop. No new sub-module.

Test Plan:
- 8b unsigned, a=200, b=3, single beat first&last -> out_data=600, out_valid 3 cycles after acceptance.
- 8b signed, a=8'h80, b=8'h7F -> out_data=32'hFFFFC080 (-16256).
- 2b signed, a=8'b11_10_01_00, b=8'hFF -> 0*-1 + 1*-1 + -2*-1 + -1*-1 = 2.
- 4b unsigned burst of 3 beats, a=8'h23, b=8'h45 each -> 23 per beat, out_data=69. Mode=0 driven on beats 2-3 is ignored.
- Backpressure: out_ready=0 for 5 cycles while results are pending -> in_ready=0 throughout, out_data stable. One result is delivered per handshake and none is lost.
- ACC_W=20, signed 8b, a=b=8'h80 (16384) for 40 beats -> with FUSION_MAC_SAT_EN: 524287 and out_sat=1. Without it: wrapped value 655360 mod 2^20 = -393216. Then rst_n pulsed mid-burst -> out_valid=0 and out_data=0 immediately.

Source files
------------

// File: rtl/fusion_pkg.sv
// Shared definitions for the Bit Fusion MAC: precision mode codes and the
// lane/slice geometry helpers used to steer and shift bitbrick products.
package fusion_pkg;

    localparam logic [1:0] MODE_2B = 2'd0;
    localparam logic [1:0] MODE_4B = 2'd1;
    localparam logic [1:0] MODE_8B = 2'd2;

    // log2 of the number of 2-bit slices per lane; mode 3 behaves as 8-bit
    function automatic int lane_slices_log2(input logic [1:0] m);
        case (m)
            MODE_2B: return 0;
            MODE_4B: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int lane_bits(input logic [1:0] m);
        return 2 << lane_slices_log2(m);
    endfunction

    // Position of a 2-bit slice inside its lane (0 = least significant)
    function automatic int slice_in_lane(input logic [1:0] m, input int idx);
        return idx & ((1 << lane_slices_log2(m)) - 1);
    endfunction

    // True when slice ia of A and slice ib of B belong to the same lane
    function automatic logic same_lane(input logic [1:0] m, input int ia, input int ib);
        return (ia >> lane_slices_log2(m)) == (ib >> lane_slices_log2(m));
    endfunction

    // Left shift applied to a brick product when rebuilding the lane product
    function automatic int brick_shift(input logic [1:0] m, input int ia, input int ib);
        return 2 * (slice_in_lane(m, ia) + slice_in_lane(m, ib));
    endfunction

endpackage

// File: rtl/bitbrick.sv
// 2-bit x 2-bit multiplier brick; each operand is optionally treated as a
// signed 2-bit value (used when the brick holds the MSB slice of a signed lane).
module bitbrick (
    input  logic              s_x_i,
    input  logic              s_y_i,
    input  logic [1:0]        x_i,
    input  logic [1:0]        y_i,
    output logic signed [5:0] p_o
);
    logic signed [2:0] x_ext;
    logic signed [2:0] y_ext;

    assign x_ext = {s_x_i & x_i[1], x_i};
    assign y_ext = {s_y_i & y_i[1], y_i};
    assign p_o   = 6'(x_ext * y_ext);

endmodule

// File: rtl/fusion_mac.sv
// Bit Fusion multiply-accumulate engine: (OPW/2)^2 bitbricks fused into a
// lane-wise dot product at 2/4/8-bit precision, accumulated over a burst.
// Pipeline: S1 brick products, S2 shift-add beat sum, S3 accumulator/output.
// Optional macro FUSION_MAC_SAT_EN: saturating accumulation plus out_sat flag.
module fusion_mac
    import fusion_pkg::*;
#(
    parameter int OPW   = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [1:0]       mode,
    input  logic             s_a,
    input  logic             s_b,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
`ifdef FUSION_MAC_SAT_EN
    ,output logic            out_sat
`endif
);
    localparam int NS = OPW / 2;
    localparam int NB = NS * NS;

    logic                    stall;
    logic                    accept;
    logic [1:0]              mode_q;
    logic                    sa_q;
    logic                    sb_q;
    logic [1:0]              eff_mode;
    logic                    eff_sa;
    logic                    eff_sb;
    logic signed [5:0]       brick_prod [NB];
    logic signed [5:0]       prod_q [NB];
    logic                    s1_vld_q, s1_first_q, s1_last_q;
    logic [1:0]              s1_mode_q;
    logic signed [ACC_W-1:0] beat_sum;
    logic signed [ACC_W-1:0] s2_sum_q;
    logic                    s2_vld_q, s2_first_q, s2_last_q;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W-1:0]        out_data_q;
    logic                    out_valid_q;
`ifdef FUSION_MAC_SAT_EN
    logic                    s1_sgn_q, s2_sgn_q;
    logic                    sat_q, sat_d, out_sat_q;
    logic [ACC_W:0]          sum_ext;
`endif

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef FUSION_MAC_SAT_EN
    assign out_sat   = out_sat_q;
`endif

    // The first beat uses its own mode/signs; later beats use the held copy
    assign eff_mode = in_first ? mode : mode_q;
    assign eff_sa   = in_first ? s_a  : sa_q;
    assign eff_sb   = in_first ? s_b  : sb_q;

    // Brick array: brick gi multiplies A slice gi%NS by B slice gi/NS
    for (genvar gi = 0; gi < NB; gi++) begin : g_brick
        localparam int IA = gi % NS;
        localparam int IB = gi / NS;
        logic              sx, sy;
        logic signed [5:0] p;

        assign sx = eff_sa & (slice_in_lane(eff_mode, IA) == lane_bits(eff_mode) / 2 - 1);
        assign sy = eff_sb & (slice_in_lane(eff_mode, IB) == lane_bits(eff_mode) / 2 - 1);

        bitbrick u_brick (
            .s_x_i (sx),
            .s_y_i (sy),
            .x_i   (a[2*IA +: 2]),
            .y_i   (b[2*IB +: 2]),
            .p_o   (p)
        );

        // Bricks pairing slices of different lanes contribute nothing
        assign brick_prod[gi] = same_lane(eff_mode, IA, IB) ? p : 6'sd0;
    end

    // Hold mode and sign flags for the rest of the burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_2B;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
        end else if (accept && in_first) begin
            mode_q <= mode;
            sa_q   <= s_a;
            sb_q   <= s_b;
        end
    end

    // S1: register gated brick products with the beat's control bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NB; n++) prod_q[n] <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= MODE_2B;
`ifdef FUSION_MAC_SAT_EN
            s1_sgn_q   <= 1'b0;
`endif
        end else if (!stall) begin
            for (int n = 0; n < NB; n++) prod_q[n] <= brick_prod[n];
            s1_vld_q   <= accept;
            s1_first_q <= in_first;
            s1_last_q  <= in_last;
            s1_mode_q  <= eff_mode;
`ifdef FUSION_MAC_SAT_EN
            s1_sgn_q   <= eff_sa | eff_sb;
`endif
        end
    end

    // Shift-add reduction of the brick products into one beat sum
    always_comb begin
        beat_sum = '0;
        for (int n = 0; n < NB; n++) begin
            beat_sum = beat_sum + (ACC_W'(prod_q[n]) <<< brick_shift(s1_mode_q, n % NS, n / NS));
        end
    end

    // S2: register the beat sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
`ifdef FUSION_MAC_SAT_EN
            s2_sgn_q   <= 1'b0;
`endif
        end else if (!stall) begin
            s2_sum_q   <= beat_sum;
            s2_vld_q   <= s1_vld_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
`ifdef FUSION_MAC_SAT_EN
            s2_sgn_q   <= s1_sgn_q;
`endif
        end
    end

    // Next accumulator value: load on first beat, otherwise add (wrap or clamp)
    always_comb begin
        acc_d = acc_q;
`ifdef FUSION_MAC_SAT_EN
        sat_d   = sat_q;
        sum_ext = '0;
`endif
        if (s2_first_q) begin
            acc_d = s2_sum_q;
`ifdef FUSION_MAC_SAT_EN
            sat_d = 1'b0;
`endif
        end else begin
`ifdef FUSION_MAC_SAT_EN
            if (s2_sgn_q) begin
                sum_ext = {acc_q[ACC_W-1], acc_q} + {s2_sum_q[ACC_W-1], s2_sum_q};
                acc_d   = sum_ext[ACC_W-1:0];
                if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
                    acc_d = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
                    sat_d = 1'b1;
                end
            end else begin
                sum_ext = {1'b0, acc_q} + {1'b0, s2_sum_q};
                acc_d   = sum_ext[ACC_W-1:0];
                if (sum_ext[ACC_W]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end
            end
`else
            acc_d = acc_q + s2_sum_q;
`endif
        end
    end

    // S3: accumulator and output register; a finished burst raises out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef FUSION_MAC_SAT_EN
            sat_q       <= 1'b0;
            out_sat_q   <= 1'b0;
`endif
        end else if (!stall) begin
            out_valid_q <= s2_vld_q & s2_last_q;
            if (s2_vld_q) begin
                acc_q <= acc_d;
`ifdef FUSION_MAC_SAT_EN
                sat_q <= sat_d;
`endif
                if (s2_last_q) begin
                    out_data_q <= acc_d;
`ifdef FUSION_MAC_SAT_EN
                    out_sat_q  <= sat_d;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fusion_mac.sv
// Directed bench for fusion_mac: a 32-bit-accumulator instance for the main
// vectors and a 20-bit instance sharing the same stimulus for the wrap/clamp case.
module tb_fusion_mac;
    import fusion_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_first, in_last;
    logic [1:0]  mode;
    logic        s_a, s_b;
    logic [7:0]  a, b;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic        in_ready20, out_valid20;
    logic [19:0] out_data20;
`ifdef FUSION_MAC_SAT_EN
    logic        out_sat, out_sat20;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fusion_mac #(.OPW(8), .ACC_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last),
        .mode(mode), .s_a(s_a), .s_b(s_b), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef FUSION_MAC_SAT_EN
        , .out_sat(out_sat)
`endif
    );

    fusion_mac #(.OPW(8), .ACC_W(20)) u_dut20 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready20),
        .in_first(in_first), .in_last(in_last),
        .mode(mode), .s_a(s_a), .s_b(s_b), .a(a), .b(b),
        .out_valid(out_valid20), .out_ready(out_ready), .out_data(out_data20)
`ifdef FUSION_MAC_SAT_EN
        , .out_sat(out_sat20)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // Present one beat at a negedge and return at the negedge after it is accepted
    task automatic send(input logic f, input logic l, input logic [1:0] m,
                        input logic sa_v, input logic sb_v,
                        input logic [7:0] av, input logic [7:0] bv);
        int n;
        in_first = f; in_last = l; mode = m; s_a = sa_v; s_b = sb_v;
        a = av; b = bv; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result on the 32-bit instance, check it, let it drain
    task automatic wait_result(input string tag, input logic [63:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
        chk(tag, 64'(out_data), exp);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        mode = MODE_2B; s_a = 1'b0; s_b = 1'b0; a = '0; b = '0; out_ready = 1'b1;

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // 8b unsigned single beat with latency check
        send(1, 1, MODE_8B, 0, 0, 8'd200, 8'd3);
        chk("lat_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_c2", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_c3", 64'(out_valid), 64'd1);
        chk("u8_200x3", 64'(out_data), 64'd600);
        @(negedge clk);
        chk("valid_drop", 64'(out_valid), 64'd0);

        // 8b signed
        send(1, 1, MODE_8B, 1, 1, 8'h80, 8'h7F);
        wait_result("s8_80x7f", 64'h0000_0000_FFFF_C080);

        // 2b signed lanes
        send(1, 1, MODE_2B, 1, 1, 8'b11_10_01_00, 8'hFF);
        wait_result("s2_dot", 64'd2);

        // 4b unsigned burst, later beats carry a different mode that must be ignored
        send(1, 0, MODE_4B, 0, 0, 8'h23, 8'h45);
        send(0, 0, MODE_2B, 1, 0, 8'h23, 8'h45);
        send(0, 1, MODE_2B, 1, 0, 8'h23, 8'h45);
        wait_result("u4_burst", 64'd69);

        // Backpressure: three single-beat results queued behind a stalled output
        out_ready = 1'b0;
        send(1, 1, MODE_8B, 0, 0, 8'd10, 8'd10);
        send(1, 1, MODE_8B, 0, 0, 8'd5, 8'd7);
        send(1, 1, MODE_8B, 1, 0, 8'hFD, 8'd7);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_data", 64'(out_data), 64'd100);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_r2_valid", 64'(out_valid), 64'd1);
        chk("bp_r2_data", 64'(out_data), 64'd35);
        @(negedge clk);
        chk("bp_r3_valid", 64'(out_valid), 64'd1);
        chk("bp_r3_data", 64'(out_data), 64'h0000_0000_FFFF_FFEB);
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // 40 beats of (-128)*(-128): wraps or clamps in the 20-bit instance
        send(1, 0, MODE_8B, 1, 1, 8'h80, 8'h80);
        for (int k = 0; k < 38; k++) send(0, 0, MODE_8B, 1, 1, 8'h80, 8'h80);
        send(0, 1, MODE_8B, 1, 1, 8'h80, 8'h80);
        for (int n = 0; n < 20 && !out_valid20; n++) @(negedge clk);
        chk("acc20_valid", 64'(out_valid20), 64'd1);
        chk("acc32_long", 64'(out_data), 64'd655360);
`ifdef FUSION_MAC_SAT_EN
        chk("acc20_sat_data", 64'(out_data20), 64'd524287);
        chk("acc20_sat_flag", 64'(out_sat20), 64'd1);
        chk("acc32_sat_flag", 64'(out_sat), 64'd0);
`else
        chk("acc20_wrap_data", 64'(out_data20), 64'h0A0000);
`endif
        @(negedge clk);

        // Reset in the middle of a burst clears outputs asynchronously
        send(1, 0, MODE_8B, 1, 1, 8'h80, 8'h80);
        send(0, 0, MODE_8B, 1, 1, 8'h80, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid20", 64'(out_valid20), 64'd0);
        chk("midrst_data20", 64'(out_data20), 64'd0);
        chk("midrst_data32", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Orphan beat after reset accumulates onto zero
        send(0, 1, MODE_8B, 0, 0, 8'd1, 8'd1);
        wait_result("orphan_beat", 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
